rf_wr_arbiter: RTL
==================

Name: rf_wr_arbiter

Overview:
Sequences and shares the single register-file write port (we/wa/wd) between two writers. The primary writer is the pipeline writeback stage. The secondary writer is a multi-cycle unit such as a mul/div or load-return path, which goes through a small FIFO. The block applies a starvation guard, drops writes to r0, and publishes a pending-write scoreboard so decode can stall on RAW hazards.

Parameters:
DEPTH, 2, secondary FIFO entries (power of 2, >=2)
STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose arbitration before it is forced

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
p_valid  input  1  primary write request
p_ready  output  1  primary accepted this cycle when p_valid && p_ready
p_wa  input  5  primary destination register
p_wd  input  32  primary write data
s_valid  input  1  secondary write request
s_ready  output  1  secondary FIFO can accept
s_wa  input  5  secondary destination register
s_wd  input  32  secondary write data
rf_we  output  1  register-file write enable (registered)
rf_wa  output  5  register-file write address (registered)
rf_wd  output  32  register-file write data (registered)
pending  output  32  bit r=1: a write to r is queued or in the output stage
s_count  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): FIFO empty, s_count=0, starve_cnt=0, rf_we=0, rf_wa=0, rf_wd=0, pending=0. p_ready=0 and s_ready=0 while rst_n=0. Reset mid-operation discards queued and in-flight writes with no partial write.
- Enqueue: when s_valid && s_ready, {s_wa,s_wd} is pushed at the edge.
  - s_ready = !full. There is no full-bypass: a full FIFO stays not-ready even if it is popping that cycle.
  - A newly pushed entry becomes visible as head only on the next cycle, so minimum secondary latency is 2 cycles from acceptance to rf_we.
- Force: force = (starve_cnt >= STARVE_LIMIT) && FIFO non-empty.
- Grant, combinational, evaluated each cycle:
  - if force, grant FIFO head and set p_ready=0;
  - else if p_valid, grant primary and set p_ready=1;
  - else if FIFO non-empty, grant FIFO head;
  - else idle.
  - Outside force, p_ready=1 (independent of p_valid).
- Output stage: at each edge rf_we <= granted && (granted wa != 0). rf_wa and rf_wd load the granted wa/wd whenever a grant occurs; otherwise they hold. Primary latency is 1 cycle.
- r0 writes: accepted and consumed normally (FIFO pops, primary handshake completes), but rf_we=0 and no pending bit is set.
- starve_cnt:
  - clears to 0 when the FIFO is empty or its head is granted;
  - increments, saturating at STARVE_LIMIT, when the FIFO is non-empty and primary wins.
- Pop and push in the same cycle (not full): occupancy is unchanged and ordering is preserved, strictly FIFO.
- Pointers wrap modulo DEPTH.
- pending[r] = OR over valid FIFO entries of (wa==r), OR (rf_we && rf_wa==r). pending[0] is always 0. Same-address duplicates keep the bit set until the last one drains.
- Ordering between a primary and a secondary write to the same register is the requesters' responsibility. Decode uses pending to avoid issuing such a pair.

Test Plan:
- Reset, then p_valid=1, p_wa=5, p_wd=0xDEADBEEF for 1 cycle -> next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; the cycle after, rf_we=0.
- Secondary only: s_wa=7, s_wd=0x11, then s_wa=8, s_wd=0x22 on consecutive cycles -> rf_we with wa=7 two cycles after the first accept, then wa=8 the next cycle. pending[7] and pending[8] are set from accept until their rf_we cycle ends.
- Fill: 3 back-to-back secondary pushes while primary is valid every cycle -> s_ready=0 after the 2nd push. With STARVE_LIMIT=4, the 5th cycle with a non-empty FIFO has p_ready=0 and the head (first entry) is written; starve_cnt returns to 0.
- p_wa=0, p_wd=0xFFFFFFFF, plus a queued secondary with s_wa=0 -> both handshakes complete and the FIFO drains, but rf_we stays 0 throughout and pending stays 0.
- Simultaneous push/pop at s_count=1 -> s_count remains 1 and output order matches push order.
- rst_n pulsed low for a partial cycle with 2 entries queued -> s_count=0, pending=0 and rf_we=0 immediately; no further rf_we occurs after release.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter
// Shares the single register-file write port between two writers:
//   - primary   : pipeline writeback, 1-cycle latency, wins by default
//   - secondary : multi-cycle unit, queued through a DEPTH-entry FIFO
// A starvation guard forces the FIFO head once the FIFO has lost arbitration
// for STARVE_LIMIT consecutive cycles. Writes to r0 are consumed but never
// reach the register file. The pending vector flags every register with a
// write still queued or sitting in the output stage, so decode can stall.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   p_valid/p_ready        primary handshake, p_wa/p_wd address/data
//   s_valid/s_ready        secondary handshake, s_wa/s_wd address/data
//   rf_we/rf_wa/rf_wd      registered register-file write port
//   pending                per-register outstanding-write flags (bit 0 = 0)
//   s_count                FIFO occupancy
module rf_wr_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     p_valid,
    output logic                     p_ready,
    input  logic [4:0]               p_wa,
    input  logic [31:0]              p_wd,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [4:0]               s_wa,
    input  logic [31:0]              s_wd,
    output logic                     rf_we,
    output logic [4:0]               rf_wa,
    output logic [31:0]              rf_wd,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   s_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [DEPTH-1:0][4:0]  mem_wa;
    logic [DEPTH-1:0][31:0] mem_wd;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [SW-1:0]          starve_cnt;

    logic        empty, full, force_s;
    logic        push, grant_p, grant_s;
    logic [4:0]  g_wa;
    logic [31:0] g_wd;

    assign empty   = (s_count == '0);
    assign full    = (s_count == CW'(DEPTH));
    assign force_s = (starve_cnt >= SW'(STARVE_LIMIT)) && !empty;

    // Both readies are held low during reset so nothing is accepted.
    // s_ready deliberately ignores a same-cycle pop (no full bypass).
    assign s_ready = rst_n && !full;
    assign p_ready = rst_n && !force_s;

    assign push    = s_valid && s_ready;
    assign grant_p = p_valid && p_ready;
    assign grant_s = !empty && (force_s || !p_valid);

    assign g_wa = grant_s ? mem_wa[rd_ptr] : p_wa;
    assign g_wd = grant_s ? mem_wd[rd_ptr] : p_wd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wa     <= '0;
            mem_wd     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            s_count    <= '0;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_wa      <= '0;
            rf_wd      <= '0;
        end else begin
            if (push) begin
                mem_wa[wr_ptr] <= s_wa;
                mem_wd[wr_ptr] <= s_wd;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (grant_s)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, grant_s})
                2'b10:   s_count <= s_count + 1'b1;
                2'b01:   s_count <= s_count - 1'b1;
                default: s_count <= s_count;
            endcase

            // Counts only cycles where a waiting FIFO head loses to primary.
            if (empty || grant_s)
                starve_cnt <= '0;
            else if (grant_p && (starve_cnt < SW'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + 1'b1;

            // r0 writes are consumed but suppressed at the port.
            rf_we <= (grant_p || grant_s) && (g_wa != 5'd0);
            if (grant_p || grant_s) begin
                rf_wa <= g_wa;
                rf_wd <= g_wd;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the
    // occupancy; this covers wrapped pointers without per-entry valid bits.
    always_comb begin
        logic [PW-1:0] off;
        pending = '0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (CW'(off) < s_count)
                pending[mem_wa[i]] = 1'b1;
        end
        if (rf_we)
            pending[rf_wa] = 1'b1;
        pending[0] = 1'b0;
    end

endmodule
